// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, opcode field and request-unit state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDI  = 6'b001000,
        LW    = 6'b100011,
        SW    = 6'b101011,
        HALT  = 6'b111111
    } opcode_t;

    // IFETCH: waiting on instruction; DMEM: holding datapath for a load/store;
    // HALTED: absorbing, left only through reset.
    typedef enum logic [1:0] {
        IFETCH = 2'd0,
        DMEM   = 2'd1,
        HALTED = 2'd2
    } req_state_t;

endpackage

// File: rtl/request_unit_sat_counter.sv
// Saturating up-counter used for the request unit's optional performance counters.
// Latency: count reflects an enable one cycle later; holds at all-ones once reached.
// Backpressure: none; increments whenever en is high and not saturated.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/request_unit.sv
// Sequences instruction/data memory requests and gates PC advance and register write.
// Latency: non-memory instr retires in its ihit cycle; load/store issues data request 1 cycle after ihit, retires on dhit.
// Backpressure: datapath held (pc_en=0) while a data access is outstanding; HALTED absorbs until RST.
// Optional feature: REQUEST_UNIT_PERF_EN adds saturating instr_cnt/stall_cnt counters.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             iread,
    input  logic             dread,
    input  logic             dwrite,
    input  logic             RegWr,
    input  logic             halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             reg_wen,
    output logic             halt_o
`ifdef REQUEST_UNIT_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    req_state_t r_state;
    req_state_t w_next_state;
    logic       r_dmem_ren;
    logic       r_dmem_wen;
    logic       r_halt;
    logic       w_dmem_ren_nxt;
    logic       w_dmem_wen_nxt;
    logic       w_halt_nxt;
    logic       w_imem_ren;
    logic       w_pc_en;
    logic       w_reg_wen;

    // State and registered request strobes; reset drops any in-flight data request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IFETCH;
            r_dmem_ren <= 1'b0;
            r_dmem_wen <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_dmem_ren <= w_dmem_ren_nxt;
            r_dmem_wen <= w_dmem_wen_nxt;
            r_halt     <= w_halt_nxt;
        end
    end

    // Next-state and combinational retire strobes; a store wins over a load when both decode.
    always_comb begin
        w_next_state   = r_state;
        w_dmem_ren_nxt = r_dmem_ren;
        w_dmem_wen_nxt = r_dmem_wen;
        w_halt_nxt     = r_halt;
        w_imem_ren     = 1'b0;
        w_pc_en        = 1'b0;
        w_reg_wen      = 1'b0;
        unique case (r_state)
            IFETCH: begin
                w_imem_ren = iread;
                if (ihit) begin
                    if (halt) begin
                        w_next_state = HALTED;
                        w_halt_nxt   = 1'b1;
                    end else if (dread || dwrite) begin
                        w_next_state   = DMEM;
                        w_dmem_wen_nxt = dwrite;
                        w_dmem_ren_nxt = dread & ~dwrite;
                    end else begin
                        w_pc_en   = 1'b1;
                        w_reg_wen = RegWr;
                    end
                end
            end
            DMEM: begin
                if (dhit) begin
                    w_next_state   = IFETCH;
                    w_dmem_ren_nxt = 1'b0;
                    w_dmem_wen_nxt = 1'b0;
                    w_pc_en        = 1'b1;
                    w_reg_wen      = RegWr;
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state   = IFETCH;
                w_dmem_ren_nxt = 1'b0;
                w_dmem_wen_nxt = 1'b0;
            end
        endcase
    end

    // Retire strobes are suppressed while reset is held so no PC update leaks out of it.
    assign imemREN = w_imem_ren;
    assign pc_en   = w_pc_en & ~RST;
    assign reg_wen = w_reg_wen & ~RST;
    assign dmemREN = r_dmem_ren;
    assign dmemWEN = r_dmem_wen;
    assign halt_o  = r_halt;

`ifdef REQUEST_UNIT_PERF_EN
    logic w_stall_en;

    // A stall cycle is any DMEM cycle the data access has not completed yet.
    assign w_stall_en = (r_state == DMEM) && !dhit;

    sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (pc_en),
        .count (instr_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (w_stall_en),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: per-cycle model comparison plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_request_unit;

    localparam int CNT_W = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ihit = 1'b0, dhit = 1'b0, iread = 1'b1, dread = 1'b0, dwrite = 1'b0;
    logic RegWr = 1'b0, halt = 1'b0;
    logic imemREN, dmemREN, dmemWEN, pc_en, reg_wen, halt_o;
`ifdef REQUEST_UNIT_PERF_EN
    logic [CNT_W-1:0] instr_cnt, stall_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    request_unit #(.CNT_W(CNT_W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ihit    (ihit),
        .dhit    (dhit),
        .iread   (iread),
        .dread   (dread),
        .dwrite  (dwrite),
        .RegWr   (RegWr),
        .halt    (halt),
        .imemREN (imemREN),
        .dmemREN (dmemREN),
        .dmemWEN (dmemWEN),
        .pc_en   (pc_en),
        .reg_wen (reg_wen),
        .halt_o  (halt_o)
`ifdef REQUEST_UNIT_PERF_EN
        ,
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "waiting for instruction", "waiting for data (read or write)", "halted".
    bit       m_wait_data = 1'b0;
    bit       m_halted    = 1'b0;
    bit       m_rd        = 1'b0;
    bit       m_wr        = 1'b0;
    longint   m_instr     = 0;
    longint   m_stall     = 0;
    longint   sat_max     = (64'd1 << CNT_W) - 1;

    function automatic bit retire_now();
        if (RST || m_halted) return 1'b0;
        if (m_wait_data) return dhit;
        return ihit && !halt && !(dread || dwrite);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_wait_data = 1'b0; m_halted = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
            m_instr = 0; m_stall = 0;
        end else if (!m_halted) begin
            if (retire_now() && m_instr < sat_max) m_instr++;
            if (m_wait_data) begin
                if (dhit) begin
                    m_wait_data = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
                end else if (m_stall < sat_max) begin
                    m_stall++;
                end
            end else if (ihit) begin
                if (halt) m_halted = 1'b1;
                else if (dread || dwrite) begin
                    m_wait_data = 1'b1; m_wr = dwrite; m_rd = dread && !dwrite;
                end
            end
        end
    end

    // Compare every cycle on the falling edge, away from state updates.
    always @(negedge CLK) begin
        chk("imemREN", 64'(imemREN), 64'(iread && !m_wait_data && !m_halted));
        chk("dmemREN", 64'(dmemREN), 64'(m_rd));
        chk("dmemWEN", 64'(dmemWEN), 64'(m_wr));
        chk("pc_en",   64'(pc_en),   64'(retire_now()));
        chk("reg_wen", 64'(reg_wen), 64'(retire_now() && RegWr));
        chk("halt_o",  64'(halt_o),  64'(m_halted));
`ifdef REQUEST_UNIT_PERF_EN
        chk("instr_cnt", 64'(instr_cnt), 64'(m_instr));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end

    // Apply one cycle of inputs just after the rising edge.
    task automatic cyc(input bit ih, input bit dh, input bit dr, input bit dw,
                       input bit rw, input bit ht);
        @(posedge CLK); #1;
        ihit = ih; dhit = dh; dread = dr; dwrite = dw; RegWr = rw; halt = ht;
    endtask

    task automatic at_mid();
        @(negedge CLK); #1;
    endtask

    initial begin
        iread = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        at_mid();
        chk("rst_imemREN", 64'(imemREN), 64'd1);
        chk("rst_pc_en",   64'(pc_en),   64'd0);
        chk("rst_dmemREN", 64'(dmemREN), 64'd0);
        chk("rst_dmemWEN", 64'(dmemWEN), 64'd0);
        chk("rst_halt_o",  64'(halt_o),  64'd0);

        // Plain ALU instruction retires in its ihit cycle.
        cyc(1, 0, 0, 0, 1, 0); at_mid();
        chk("alu_pc_en",   64'(pc_en),   64'd1);
        chk("alu_reg_wen", 64'(reg_wen), 64'd1);
        chk("alu_dmemREN", 64'(dmemREN), 64'd0);

        // Load: request next cycle, dhit three cycles after ihit.
        cyc(1, 0, 1, 0, 1, 0); at_mid();
        chk("ld_ihit_pc_en", 64'(pc_en), 64'd0);
        cyc(0, 0, 0, 0, 1, 0); at_mid();
        chk("ld_dmemREN", 64'(dmemREN), 64'd1);
        chk("ld_imemREN", 64'(imemREN), 64'd0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0); at_mid();
        chk("ld_pc_en",   64'(pc_en),   64'd1);
        chk("ld_reg_wen", 64'(reg_wen), 64'd1);
        cyc(0, 0, 0, 0, 0, 0); at_mid();
        chk("ld_done_dmemREN", 64'(dmemREN), 64'd0);
        chk("ld_done_pc_en",   64'(pc_en),   64'd0);
`ifdef REQUEST_UNIT_PERF_EN
        chk("ld_instr_cnt", 64'(instr_cnt), 64'd2);
        chk("ld_stall_cnt", 64'(stall_cnt), 64'd2);
`endif

        // Stray dhit in IFETCH is dropped; then load+store decodes as a store.
        cyc(0, 1, 0, 0, 1, 0); at_mid();
        chk("stray_dhit_pc_en", 64'(pc_en), 64'd0);
        cyc(1, 1, 1, 1, 0, 0); at_mid();
        chk("both_ihit_pc_en", 64'(pc_en), 64'd0);
        cyc(1, 0, 0, 0, 0, 0); at_mid();
        chk("st_dmemWEN",        64'(dmemWEN), 64'd1);
        chk("st_dmemREN",        64'(dmemREN), 64'd0);
        chk("dmem_ihit_ignored", 64'(pc_en),   64'd0);

        // Reset mid-store clears strobes immediately.
        cyc(0, 0, 0, 0, 0, 0); at_mid();
        RST = 1'b1; #1;
        chk("arst_dmemWEN", 64'(dmemWEN), 64'd0);
        chk("arst_halt_o",  64'(halt_o),  64'd0);
        chk("arst_imemREN", 64'(imemREN), 64'd1);
        @(posedge CLK); #1 RST = 1'b0;
`ifdef REQUEST_UNIT_PERF_EN
        at_mid();
        chk("arst_instr_cnt", 64'(instr_cnt), 64'd0);
        chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        // Store completing in the very next cycle: 2-cycle minimum, no register write.
        cyc(1, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0); at_mid();
        chk("st_pc_en",   64'(pc_en),   64'd1);
        chk("st_reg_wen", 64'(reg_wen), 64'd0);

        // Halt is absorbing.
        cyc(1, 0, 0, 0, 1, 1); at_mid();
        chk("halt_pc_en", 64'(pc_en), 64'd0);
        cyc(0, 0, 0, 0, 0, 0); at_mid();
        chk("halted_halt_o",  64'(halt_o),  64'd1);
        chk("halted_imemREN", 64'(imemREN), 64'd0);
        cyc(1, 1, 1, 0, 1, 0); at_mid();
        chk("halted_pc_en",   64'(pc_en),   64'd0);
        chk("halted_dmemREN", 64'(dmemREN), 64'd0);
        cyc(1, 0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 1, 0); at_mid();
        chk("halted_dmemWEN", 64'(dmemWEN), 64'd0);
`ifdef REQUEST_UNIT_PERF_EN
        chk("halted_instr_cnt", 64'(instr_cnt), 64'd1);
        chk("halted_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        cyc(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        at_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
